// File: rtl/core_host_loader.sv
`default_nettype none
// ============================================================================
// core_host_loader
// Host-side loader: turns a header/payload word stream into timed strobes on
// the core's memory load/dump ports, and drives core run/halt and mem-clear.
// Revision: 1.0
// ============================================================================
module core_host_loader #(
    parameter int unsigned WR_HOLD    = 2,
    parameter int unsigned RD_LAT     = 4,
    parameter int unsigned CLR_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        core_reset_n,
    output logic        mem_clr_n,
    output logic        write_ins,
    output logic [7:0]  addr_ins,
    output logic [31:0] dati_ins,
    output logic        write_data,
    output logic        read_data,
    output logic [7:0]  addr_data,
    output logic [31:0] dati_data,
    input  logic [31:0] dato_data,
    output logic        busy,
    output logic        err
);

    localparam logic [15:0] c_WR_RELOAD  = 16'(WR_HOLD - 1);
    localparam logic [15:0] c_RD_RELOAD  = 16'(RD_LAT - 1);
    localparam logic [15:0] c_CLR_RELOAD = 16'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_WAIT = 3'd1,
        S_LD_WR   = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_OUT  = 3'd4,
        S_CLR     = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_hold;
    logic [7:0]  r_addr;
    logic [8:0]  r_cnt;
    logic        r_is_data;
    logic        r_discard;

    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_core_reset_n;
    logic        r_mem_clr_n;
    logic        r_write_ins;
    logic [7:0]  r_addr_ins;
    logic [31:0] r_dati_ins;
    logic        r_write_data;
    logic        r_read_data;
    logic [7:0]  r_addr_data;
    logic [31:0] r_dati_data;
    logic        r_busy;
    logic        r_err;

    logic        w_hs_in;
    logic        w_hs_out;
    logic [3:0]  w_op;
    logic        w_halted;
    logic        w_last;
    logic        w_hold_done;

    assign w_hs_in     = in_valid & r_in_ready;
    assign w_hs_out    = r_out_valid & out_ready;
    assign w_op        = in_data[31:28];
    assign w_halted    = ~r_core_reset_n;
    assign w_last      = (r_cnt == 9'd1);
    assign w_hold_done = (r_hold == 16'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_hold         <= 16'd0;
            r_addr         <= 8'd0;
            r_cnt          <= 9'd0;
            r_is_data      <= 1'b0;
            r_discard      <= 1'b0;
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= 32'd0;
            r_core_reset_n <= 1'b0;
            r_mem_clr_n    <= 1'b1;
            r_write_ins    <= 1'b0;
            r_addr_ins     <= 8'd0;
            r_dati_ins     <= 32'd0;
            r_write_data   <= 1'b0;
            r_read_data    <= 1'b0;
            r_addr_data    <= 8'd0;
            r_dati_data    <= 32'd0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_in_ready) begin
                        r_in_ready <= 1'b1;
                    end else if (in_valid) begin
                        r_addr <= in_data[15:8];
                        r_cnt  <= {1'b0, in_data[7:0]} + 9'd1;
                        case (w_op)
                            4'h1, 4'h2: begin
                                // A running core still gets its payload drained to keep framing
                                r_is_data <= (w_op == 4'h2);
                                r_discard <= ~w_halted;
                                r_err     <= r_err | ~w_halted;
                                r_state   <= S_LD_WAIT;
                                r_busy    <= 1'b1;
                            end
                            4'h3: begin
                                if (w_halted) begin
                                    r_state     <= S_RD_WAIT;
                                    r_busy      <= 1'b1;
                                    r_in_ready  <= 1'b0;
                                    r_read_data <= 1'b1;
                                    r_addr_data <= in_data[15:8];
                                    r_hold      <= c_RD_RELOAD;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            4'h4: r_core_reset_n <= 1'b1;
                            4'h5: r_core_reset_n <= 1'b0;
                            4'h6: begin
                                if (w_halted) begin
                                    r_state     <= S_CLR;
                                    r_busy      <= 1'b1;
                                    r_in_ready  <= 1'b0;
                                    r_mem_clr_n <= 1'b0;
                                    r_hold      <= c_CLR_RELOAD;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end

                S_LD_WAIT: begin
                    if (w_hs_in) begin
                        if (r_discard) begin
                            r_cnt <= r_cnt - 9'd1;
                            if (w_last) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_state    <= S_LD_WR;
                            r_in_ready <= 1'b0;
                            r_hold     <= c_WR_RELOAD;
                            if (r_is_data) begin
                                r_write_data <= 1'b1;
                                r_addr_data  <= r_addr;
                                r_dati_data  <= in_data;
                            end else begin
                                r_write_ins <= 1'b1;
                                r_addr_ins  <= r_addr;
                                r_dati_ins  <= in_data;
                            end
                        end
                    end
                end

                S_LD_WR: begin
                    if (w_hold_done) begin
                        r_write_ins  <= 1'b0;
                        r_write_data <= 1'b0;
                        r_dati_data  <= 32'd0;
                        r_addr       <= r_addr + 8'd1;
                        r_cnt        <= r_cnt - 9'd1;
                        r_in_ready   <= 1'b1;
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_LD_WAIT;
                        end
                    end else begin
                        r_hold <= r_hold - 16'd1;
                    end
                end

                S_RD_WAIT: begin
                    if (w_hold_done) begin
                        r_read_data <= 1'b0;
                        r_out_data  <= dato_data;
                        r_out_valid <= 1'b1;
                        r_state     <= S_RD_OUT;
                    end else begin
                        r_hold <= r_hold - 16'd1;
                    end
                end

                S_RD_OUT: begin
                    if (w_hs_out) begin
                        r_out_valid <= 1'b0;
                        r_cnt       <= r_cnt - 9'd1;
                        if (w_last) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_addr      <= r_addr + 8'd1;
                            r_addr_data <= r_addr + 8'd1;
                            r_read_data <= 1'b1;
                            r_hold      <= c_RD_RELOAD;
                            r_state     <= S_RD_WAIT;
                        end
                    end
                end

                S_CLR: begin
                    if (w_hold_done) begin
                        r_mem_clr_n <= 1'b1;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_hold <= r_hold - 16'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign core_reset_n = r_core_reset_n;
    assign mem_clr_n    = r_mem_clr_n;
    assign write_ins    = r_write_ins;
    assign addr_ins     = r_addr_ins;
    assign dati_ins     = r_dati_ins;
    assign write_data   = r_write_data;
    assign read_data    = r_read_data;
    assign addr_data    = r_addr_data;
    assign dati_data    = r_dati_data;
    assign busy         = r_busy;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_core_host_loader.sv
`default_nettype none
// ============================================================================
// tb_core_host_loader
// Directed testbench for core_host_loader with a small data-memory model.
// Revision: 1.0
// ============================================================================
module tb_core_host_loader;

    localparam int WR_HOLD    = 2;
    localparam int RD_LAT     = 4;
    localparam int CLR_CYCLES = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic        core_reset_n, mem_clr_n, write_ins, write_data, read_data, busy, err;
    logic [7:0]  addr_ins, addr_data;
    logic [31:0] dati_ins, dati_data, dato_data;

    core_host_loader #(
        .WR_HOLD   (WR_HOLD),
        .RD_LAT    (RD_LAT),
        .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .core_reset_n(core_reset_n),
        .mem_clr_n   (mem_clr_n),
        .write_ins   (write_ins),
        .addr_ins    (addr_ins),
        .dati_ins    (dati_ins),
        .write_data  (write_data),
        .read_data   (read_data),
        .addr_data   (addr_data),
        .dati_data   (dati_data),
        .dato_data   (dato_data),
        .busy        (busy),
        .err         (err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Data-memory model
    logic [31:0] dmem [256];
    assign dato_data = dmem[addr_data];
    always @(posedge clock) if (write_data) dmem[addr_data] <= dati_data;

    // Strobe-run recorders (sampled on the falling edge)
    int          ins_n = 0, dat_n = 0, rd_n = 0, excl_bad = 0;
    logic [7:0]  ins_addr [64];
    logic [31:0] ins_data [64];
    int          ins_len  [64];
    logic [7:0]  dat_addr [64];
    logic [31:0] dat_data [64];
    int          dat_len  [64];
    logic [7:0]  rd_addr  [64];
    int          rd_len   [64];
    logic        prev_wi = 1'b0, prev_wd = 1'b0, prev_rd = 1'b0;

    always @(negedge clock) begin
        if (write_ins && !prev_wi && ins_n < 64) begin
            ins_addr[ins_n] = addr_ins; ins_data[ins_n] = dati_ins; ins_len[ins_n] = 1; ins_n++;
        end else if (write_ins && prev_wi && ins_n > 0) begin
            ins_len[ins_n-1]++;
        end
        if (write_data && !prev_wd && dat_n < 64) begin
            dat_addr[dat_n] = addr_data; dat_data[dat_n] = dati_data; dat_len[dat_n] = 1; dat_n++;
        end else if (write_data && prev_wd && dat_n > 0) begin
            dat_len[dat_n-1]++;
        end
        if (read_data && !prev_rd && rd_n < 64) begin
            rd_addr[rd_n] = addr_data; rd_len[rd_n] = 1; rd_n++;
        end else if (read_data && prev_rd && rd_n > 0) begin
            rd_len[rd_n-1]++;
        end
        if ((write_ins && write_data) || (write_ins && read_data) || (write_data && read_data))
            excl_bad++;
        prev_wi = write_ins; prev_wd = write_data; prev_rd = read_data;
    end

    // All tasks start and end #1 after a rising edge.
    task automatic send(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 100) begin
            @(posedge clock); #1; n++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: word %h not accepted, in_ready=%b want 1", w, in_ready);
        end else begin
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clock); #1; n++;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (core_reset_n !== 1'b0) $display("FAIL rst_core_reset_n: got %b want 0", core_reset_n); else n_pass++;
        n_checks++; if (mem_clr_n !== 1'b1) $display("FAIL rst_mem_clr_n: got %b want 1", mem_clr_n); else n_pass++;
        n_checks++; if ({in_ready, out_valid, busy, err} !== 4'b0) $display("FAIL rst_flags: got %b want 0000", {in_ready, out_valid, busy, err}); else n_pass++;
        n_checks++; if ({write_ins, write_data, read_data} !== 3'b0) $display("FAIL rst_strobes: got %b want 000", {write_ins, write_data, read_data}); else n_pass++;
        n_checks++; if ({addr_ins, addr_data} !== 16'h0) $display("FAIL rst_addr: got %h want 0000", {addr_ins, addr_data}); else n_pass++;
        n_checks++; if ({dati_ins, dati_data, out_data} !== 96'h0) $display("FAIL rst_data: got %h want 0", {dati_ins, dati_data, out_data}); else n_pass++;
        reset = 1'b0;
        @(posedge clock); #1;
        n_checks++; if ({in_ready, busy} !== 2'b10) $display("FAIL rst_release: in_ready,busy got %b want 10", {in_ready, busy}); else n_pass++;
    endtask

    task automatic test_load_ins();
        logic [31:0] w [3] = '{32'hA5A5_0001, 32'h1234_5678, 32'hDEAD_BEEF};
        int t [3];
        int b  = ins_n;
        int bd = dat_n;
        send(32'h1000_0502);
        for (int i = 0; i < 3; i++) begin
            send(w[i]);
            t[i] = cyc;
        end
        wait_idle();
        n_checks++; if (ins_n - b !== 3) $display("FAIL ldins_runs: got %0d want 3", ins_n - b); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ins_addr[b+i] !== 8'(5 + i) || ins_data[b+i] !== w[i] || ins_len[b+i] !== WR_HOLD)
                $display("FAIL ldins_run%0d: got addr %h data %h len %0d want %h %h %0d",
                         i, ins_addr[b+i], ins_data[b+i], ins_len[b+i], 8'(5 + i), w[i], WR_HOLD);
            else n_pass++;
        end
        n_checks++; if (t[2] - t[1] !== WR_HOLD + 1 || t[1] - t[0] !== WR_HOLD + 1)
            $display("FAIL ldins_rate: got gaps %0d %0d want %0d", t[1] - t[0], t[2] - t[1], WR_HOLD + 1); else n_pass++;
        n_checks++; if (dat_n !== bd) $display("FAIL ldins_no_dwrite: got %0d data runs want 0", dat_n - bd); else n_pass++;
        n_checks++; if ({busy, err, in_ready} !== 3'b001) $display("FAIL ldins_end: busy,err,in_ready got %b want 001", {busy, err, in_ready}); else n_pass++;
    endtask

    task automatic test_load_dump();
        logic [31:0] w [3] = '{32'hCAFE_0000, 32'h0BAD_F00D, 32'h5555_AAAA};
        logic [31:0] first;
        int b  = dat_n;
        int br = rd_n;
        int n;
        int unstable = 0;
        send(32'h2000_FE02);
        for (int i = 0; i < 3; i++) send(w[i]);
        wait_idle();
        n_checks++; if (dat_n - b !== 3) $display("FAIL lddat_runs: got %0d want 3", dat_n - b); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dat_addr[b+i] !== 8'(8'hFE + i) || dat_data[b+i] !== w[i] || dat_len[b+i] !== WR_HOLD)
                $display("FAIL lddat_run%0d: got addr %h data %h len %0d want %h %h %0d",
                         i, dat_addr[b+i], dat_data[b+i], dat_len[b+i], 8'(8'hFE + i), w[i], WR_HOLD);
            else n_pass++;
        end
        n_checks++; if (dati_data !== 32'h0) $display("FAIL lddat_dati_idle: got %h want 0", dati_data); else n_pass++;
        out_ready = 1'b0;
        send(32'h3000_FE02);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clock); #1; n++;
            end
            n_checks++; if (out_valid !== 1'b1) $display("FAIL dump_valid%0d: got %b want 1", i, out_valid); else n_pass++;
            if (i == 0) begin
                first = out_data;
                repeat (5) begin
                    @(posedge clock); #1;
                    if (out_data !== first || out_valid !== 1'b1) unstable++;
                end
                n_checks++; if (unstable !== 0) $display("FAIL dump_stall_stable: got %0d changes want 0", unstable); else n_pass++;
            end
            n_checks++; if (out_data !== w[i]) $display("FAIL dump_word%0d: got %h want %h", i, out_data, w[i]); else n_pass++;
            out_ready = 1'b1;
            @(posedge clock); #1;
            out_ready = 1'b0;
        end
        wait_idle();
        n_checks++; if (rd_n - br !== 3) $display("FAIL dump_reads: got %0d want 3", rd_n - br); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_addr[br+i] !== 8'(8'hFE + i) || rd_len[br+i] !== RD_LAT)
                $display("FAIL dump_read%0d: got addr %h len %0d want %h %0d",
                         i, rd_addr[br+i], rd_len[br+i], 8'(8'hFE + i), RD_LAT);
            else n_pass++;
        end
        n_checks++; if ({busy, err, out_valid} !== 3'b000) $display("FAIL dump_end: busy,err,out_valid got %b want 000", {busy, err, out_valid}); else n_pass++;
    endtask

    task automatic test_clear();
        int low = 0, busy_bad = 0, n = 0;
        send(32'h6000_0000);
        while (n < 30) begin
            if (!mem_clr_n) begin
                low++;
                if (!busy) busy_bad++;
            end else if (low > 0) begin
                break;
            end
            @(posedge clock); #1; n++;
        end
        n_checks++; if (low !== CLR_CYCLES) $display("FAIL clr_width: got %0d want %0d", low, CLR_CYCLES); else n_pass++;
        n_checks++; if (busy_bad !== 0) $display("FAIL clr_busy: got %0d idle cycles want 0", busy_bad); else n_pass++;
        n_checks++; if ({busy, err} !== 2'b00) $display("FAIL clr_end: busy,err got %b want 00", {busy, err}); else n_pass++;
    endtask

    task automatic test_run_err();
        int b  = ins_n;
        int bd = dat_n;
        send(32'h4000_0000);
        n_checks++; if ({core_reset_n, busy, in_ready} !== 3'b101) $display("FAIL run_edge: core_reset_n,busy,in_ready got %b want 101", {core_reset_n, busy, in_ready}); else n_pass++;
        send(32'h1000_1001);
        send(32'h1111_1111);
        send(32'h2222_2222);
        n_checks++; if ({busy, in_ready} !== 2'b01) $display("FAIL run_discard_end: busy,in_ready got %b want 01", {busy, in_ready}); else n_pass++;
        n_checks++; if (ins_n !== b || dat_n !== bd) $display("FAIL run_no_strobe: got %0d ins %0d data runs want 0", ins_n - b, dat_n - bd); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL run_err: got %b want 1", err); else n_pass++;
        send(32'h5000_0000);
        n_checks++; if (core_reset_n !== 1'b0) $display("FAIL halt_after_run: got %b want 0", core_reset_n); else n_pass++;
    endtask

    task automatic test_bad_opcode();
        int b  = ins_n;
        int bd = dat_n;
        int br = rd_n;
        n_checks++; if (err !== 1'b0) $display("FAIL bad_pre_err: got %b want 0", err); else n_pass++;
        send(32'hF000_0102);
        n_checks++; if ({err, busy} !== 2'b10) $display("FAIL bad_op: err,busy got %b want 10", {err, busy}); else n_pass++;
        send(32'h4000_0000);
        n_checks++; if (core_reset_n !== 1'b1) $display("FAIL bad_then_run: got %b want 1", core_reset_n); else n_pass++;
        send(32'h5000_0000);
        n_checks++; if (core_reset_n !== 1'b0) $display("FAIL bad_then_halt: got %b want 0", core_reset_n); else n_pass++;
        n_checks++; if (ins_n !== b || dat_n !== bd || rd_n !== br || mem_clr_n !== 1'b1)
            $display("FAIL bad_no_action: runs %0d %0d %0d mem_clr_n %b want 0 0 0 1", ins_n - b, dat_n - bd, rd_n - br, mem_clr_n); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        out_ready = 1'b1;
        send(32'h3000_2003);
        while (!out_valid && n < 100) begin
            @(posedge clock); #1; n++;
        end
        @(posedge clock); #1;
        n_checks++; if ({read_data, busy} !== 2'b11) $display("FAIL mid_second_read: read_data,busy got %b want 11", {read_data, busy}); else n_pass++;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        n_checks++; if ({read_data, out_valid, busy, core_reset_n} !== 4'b0000)
            $display("FAIL mid_reset: read_data,out_valid,busy,core_reset_n got %b want 0000", {read_data, out_valid, busy, core_reset_n}); else n_pass++;
        reset     = 1'b0;
        out_ready = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_exclusive();
        n_checks++; if (excl_bad !== 0) $display("FAIL strobe_exclusive: got %0d overlap cycles want 0", excl_bad); else n_pass++;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        test_load_ins();
        test_load_dump();
        test_clear();
        test_run_err();
        do_reset();
        test_bad_opcode();
        do_reset();
        test_reset_mid();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
